// File: rtl/onewire_slave_pkg.sv
// Shared definitions for the 1-wire slave: FSM encoding, default 65.536MHz timings
// and the overdrive divisor. Overdrive itself is built only with OWR_OVD_EN.
package onewire_slave_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SLOT    = 3'd1,
        RST     = 3'd2,
        PD_WAIT = 3'd3,
        PD_DRV  = 3'd4,
        PD_END  = 3'd5
    } state_t;

    localparam int DEF_CW    = 16;
    localparam int DEF_T_SMP = 1966;   // 30us
    localparam int DEF_T_DRV = 2621;   // 40us
    localparam int DEF_T_RST = 28836;  // 440us
    localparam int DEF_T_PDW = 1966;   // 30us
    localparam int DEF_T_PDL = 7864;   // 120us

    // Overdrive timings are the standard ones divided by 2**OVD_SHIFT.
    localparam int OVD_SHIFT = 3;

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for an open-drain line (idles high) with a registered
// previous-value flop providing a one-cycle falling-edge strobe.
module onewire_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign fall = prev & ~q;

endmodule

// File: rtl/onewire_slave.sv
// 1-wire bus slave: reset/presence, slot decode into bytes, read-slot drive from a
// host byte. Define OWR_OVD_EN to add the `ovd` overdrive-speed input.
module onewire_slave
    import onewire_slave_pkg::*;
#(
    parameter int CW    = DEF_CW,
    parameter int T_SMP = DEF_T_SMP,
    parameter int T_DRV = DEF_T_DRV,
    parameter int T_RST = DEF_T_RST,
    parameter int T_PDW = DEF_T_PDW,
    parameter int T_PDL = DEF_T_PDL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       owr_i,
    output logic       owr_e,
    output logic       bus_rst,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_vld,
    output logic       tx_rdy,
`ifdef OWR_OVD_EN
    input  logic       ovd,
`endif
    output state_t     state
);

    logic          s;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic          tx_full;
    logic          tx_load;
    logic [1:0]    sh;
    logic [CW-1:0] t_smp, t_drv, t_rst, t_pdw, t_pdl;

    onewire_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (owr_i),
        .q    (s),
        .fall (fall)
    );

`ifdef OWR_OVD_EN
    // Speed is latched only while idle so a slot or presence never changes pace midway.
    logic ovd_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovd_q <= 1'b0;
        else if (state == IDLE)
            ovd_q <= ovd;
    end
    assign sh = ovd_q ? 2'(OVD_SHIFT) : 2'd0;
`else
    assign sh = 2'd0;
`endif

    assign t_smp = CW'(T_SMP) >> sh;
    assign t_drv = CW'(T_DRV) >> sh;
    assign t_rst = CW'(T_RST) >> sh;
    assign t_pdw = CW'(T_PDW) >> sh;
    assign t_pdl = CW'(T_PDL) >> sh;

    assign tx_rdy  = ~tx_full & (bit_cnt == 3'd0) & (state == IDLE);
    assign tx_load = tx_vld & tx_rdy;

    // Decoded from registers only, so an asynchronous reset releases the line at once.
    assign owr_e = (state == PD_DRV) |
                   ((state == SLOT) & tx_full & ~tx_sh[0] & (cnt < t_drv));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= 3'd0;
            rx_sh   <= 8'h00;
            tx_sh   <= 8'h00;
            tx_full <= 1'b0;
            rx_dat  <= 8'h00;
            rx_vld  <= 1'b0;
            bus_rst <= 1'b0;
        end else begin
            rx_vld  <= 1'b0;
            bus_rst <= 1'b0;
            if (~&cnt)
                cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (tx_load) begin
                        tx_sh   <= tx_dat;
                        tx_full <= 1'b1;
                    end
                    if (fall) begin
                        state <= SLOT;
                        cnt   <= '0;
                    end
                end

                SLOT: begin
                    if (cnt == t_smp)
                        rx_sh <= {s, rx_sh[7:1]};
                    if (!s && cnt >= t_rst) begin
                        // Long low: abandon any partial byte and the pending tx byte.
                        state   <= RST;
                        cnt     <= '0;
                        bit_cnt <= 3'd0;
                        rx_sh   <= 8'h00;
                        tx_sh   <= 8'h00;
                        tx_full <= 1'b0;
                    end else if (s && cnt > t_smp && cnt >= t_drv) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sh   <= {1'b0, tx_sh[7:1]};
                        if (bit_cnt == 3'd7) begin
                            rx_dat  <= rx_sh;
                            rx_vld  <= 1'b1;
                            tx_full <= 1'b0;
                        end
                    end
                end

                RST: begin
                    if (s) begin
                        state   <= PD_WAIT;
                        cnt     <= '0;
                        bus_rst <= 1'b1;
                    end
                end

                PD_WAIT: begin
                    if (cnt == t_pdw - 1'b1) begin
                        state <= PD_DRV;
                        cnt   <= '0;
                    end
                end

                PD_DRV: begin
                    if (cnt == t_pdl - 1'b1) begin
                        state <= PD_END;
                        cnt   <= '0;
                    end
                end

                PD_END: begin
                    // Line may still be low from our own presence or a slow master.
                    if (s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
